fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, 16, width of the PC and instruction address.
- INSTR_W, 16, instruction word width.
- TIMEOUT_CYC, 15, memory wait limit in cycles; used only with FETCH_TIMEOUT_EN.

REQ-002 The block SHALL have these ports; reset is synchronous and active-high, and the clock is clk:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  ADDR_W  current program counter value.
- pc_inc  out  1  PC increment strobe (combinational).
- pc_load  out  1  PC load strobe (combinational).
- pc_target  out  ADDR_W  PC load value (combinational).
- mem_req  out  1  instruction memory read request (registered).
- mem_addr  out  ADDR_W  instruction memory read address (registered).
- mem_ack  in  1  memory read data valid.
- mem_rdata  in  INSTR_W  memory read data.
- instr  out  INSTR_W  fetched instruction.
- instr_pc  out  ADDR_W  address of instr.
- instr_valid  out  1  instr and instr_pc are valid.
- instr_ready  in  1  decode accepts instr.
- redirect  in  1  branch or jump request, single-cycle strobe.
- redirect_addr  in  ADDR_W  branch or jump target.
- fetch_err  out  1  sticky memory timeout flag.

Function
REQ-003 The FSM SHALL have the states IDLE, REQ and HOLD, plus ERR when FETCH_TIMEOUT_EN is defined.
REQ-004 IDLE, without redirect: on the next edge, mem_addr<=pc_in, mem_req<=1, next state REQ.
REQ-005 IDLE, with redirect: the FSM SHALL stay in IDLE for one more cycle so that the loaded PC is seen.
REQ-006 REQ: mem_req and mem_addr SHALL stay stable until the first cycle with mem_ack=1.
REQ-007 REQ with mem_ack=1, discard=0 and redirect=0: mem_req<=0, instr<=mem_rdata, instr_pc<=mem_addr, instr_valid<=1, next state HOLD.
REQ-008 REQ with mem_ack=1 and either discard=1 or redirect=1: the data SHALL be dropped, mem_req<=0, discard<=0, next state IDLE.
REQ-009 REQ with redirect=1 and mem_ack=0: discard<=1, stay in REQ; the outstanding request SHALL never be withdrawn.
REQ-010 HOLD: instr_valid SHALL be held at 1 and instr/instr_pc held stable until instr_ready=1 or redirect=1.
REQ-011 HOLD with instr_ready=1 and redirect=0: pc_inc=1 in that cycle, instr_valid<=0, next state IDLE.
REQ-012 HOLD with redirect=1: instr_valid<=0, pc_inc=0, next state IDLE; redirect SHALL win over instr_ready.
REQ-013 pc_inc SHALL equal (state==HOLD) && instr_ready && !redirect.
REQ-014 pc_load SHALL equal redirect and pc_target SHALL equal redirect_addr, in every state except when reset=1.
REQ-015 pc_inc and pc_load SHALL never be asserted together.
REQ-016 mem_ack in IDLE or HOLD SHALL be ignored.
REQ-017 The minimum cadence SHALL be 3 cycles per instruction: IDLE, REQ with ack in its first cycle, and HOLD with ready in its first cycle.

Reset
REQ-018 When reset=1, the next edge SHALL force state IDLE and set mem_req, mem_addr, instr, instr_pc, instr_valid, discard, the timeout counter and fetch_err to 0; reset overrides all other inputs.
REQ-019 While reset=1, pc_inc and pc_load SHALL be 0.
REQ-020 Reset during REQ SHALL drop mem_req at the next edge; the instruction memory SHALL tolerate an abandoned request.

Configuration
REQ-021 Behaviour with FETCH_TIMEOUT_EN defined:
- A counter clears on entry to REQ and increments each REQ cycle with mem_ack=0.
- When TIMEOUT_CYC consecutive no-ack REQ cycles are reached: fetch_err<=1, mem_req<=0, next state ERR.
- mem_ack in the limit cycle wins over the timeout.
- ERR holds until reset; redirect still drives pc_load, and the state does not change.
REQ-022 Without FETCH_TIMEOUT_EN: no counter and no ERR state; fetch_err SHALL be tied to 0 and REQ SHALL wait indefinitely.

Verification
REQ-023 Reset release, pc_in=0, ack on the first REQ cycle with rdata=16'hEC10, ready=1 -> mem_addr=0; instr=EC10, instr_pc=0, valid for 1 cycle; pc_inc pulses once; the next mem_addr is 1.
REQ-024 instr_ready=0 for 4 cycles in HOLD -> instr_valid held at 1 with instr stable, pc_inc=0, mem_req=0 throughout.
REQ-025 Redirect to 16'h0040 while in REQ with ack arriving 3 cycles later -> pc_load=1 for 1 cycle, data discarded, instr_valid stays 0, next mem_addr=0x0040.
REQ-026 Redirect and instr_ready together in HOLD -> pc_load=1, pc_inc=0, instr_valid cleared.
REQ-027 With FETCH_TIMEOUT_EN and TIMEOUT_CYC=15, no ack -> fetch_err=1 after the 15th REQ cycle, mem_req drops; reset clears it. Without the macro -> mem_req is still high after 100 cycles.
REQ-028 Reset asserted on the second REQ cycle -> all outputs 0 on the next cycle; a late mem_ack is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
//==============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch sequencer (IDLE/REQ/HOLD) between PC, memory and
//            decode. Optional memory-wait timeout with sticky error: FETCH_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_unit #(
    parameter int ADDR_W      = 16,
    parameter int INSTR_W     = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_target,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               fetch_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
`ifdef FETCH_TIMEOUT_EN
    localparam logic [1:0] ST_ERR  = 2'd3;
    localparam int         CNT_W   = $clog2(TIMEOUT_CYC + 1);
`endif

    logic [1:0]         state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic               discard_q, discard_d;
`ifdef FETCH_TIMEOUT_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fetch_err_q, fetch_err_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            discard_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q         <= '0;
            fetch_err_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            discard_q     <= discard_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q         <= cnt_d;
            fetch_err_q   <= fetch_err_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        discard_d     = discard_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d         = cnt_q;
        fetch_err_d   = fetch_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A redirect this cycle loads the PC; wait so the new pc_in is used.
                if (!redirect) begin
                    mem_addr_d = pc_in;
                    mem_req_d  = 1'b1;
                    state_d    = ST_REQ;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (discard_q || redirect) begin
                        discard_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        instr_d       = mem_rdata;
                        instr_pc_d    = mem_addr_q;
                        instr_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end
                end else begin
                    // The request stays outstanding; its data is dropped on arrival.
                    if (redirect)
                        discard_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        fetch_err_d = 1'b1;
                        mem_req_d   = 1'b0;
                        state_d     = ST_ERR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            ST_HOLD: begin
                if (redirect || instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
`ifndef FETCH_TIMEOUT_EN
                state_d = ST_IDLE;
`endif
            end
        endcase
    end

    // PC control strobes
    always_comb begin
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_target = redirect_addr;
        if (!reset) begin
            pc_load = redirect;
            pc_inc  = (state_q == ST_HOLD) && instr_ready && !redirect;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err   = fetch_err_q;
`else
    assign fetch_err   = 1'b0;
`endif

endmodule

`default_nettype wire
